// File: rtl/uart_transmitter_if.sv
// Host-side handshake for the UART transmit stage: byte, start strobe, line and status.
interface uart_transmitter_if;
  logic [7:0] data_in;
  logic       tx_start;
  logic       tx;
  logic       busy;
  logic       done;
  logic       parity_out;

  modport master (
    output data_in,
    output tx_start,
    input  tx,
    input  busy,
    input  done,
    input  parity_out
  );

  modport slave (
    input  data_in,
    input  tx_start,
    output tx,
    output busy,
    output done,
    output parity_out
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmit stage: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bit timing is derived from the system clock; all outputs are registered.
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic                clk,
  input logic                reset,
  uart_transmitter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            parity_q, parity_d;
  logic            bit_end;

  assign bit_end = (baud_q == CntMax);

  always_comb begin
    state_d  = state_q;
    baud_d   = bit_end ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    parity_d = parity_q;

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.tx_start) begin
          shreg_d  = bus.data_in;
          parity_d = (^bus.data_in) ^ (PARITY_ODD != 0);
          busy_d   = 1'b1;
          tx_d     = 1'b0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          tx_d    = shreg_q[0];
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            // Next data bit is the one just above the current LSB.
            tx_d  = shreg_q[1];
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          bit_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_q == LastStop) begin
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      parity_q <= parity_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.parity_out = parity_q;

endmodule
